// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl - shared sequential shift-and-add multiplier controller.
//
// Two requesters share one WIDTH-bit ripple adder made of f_adder cells.
// One operand pair is accepted at a time. The adder runs once per cycle for
// WIDTH cycles and forms the unsigned 2*WIDTH-bit product, which is returned
// with the issuing requester's ID on a valid/ready response port.
//
// Optional feature macro: MULT_RR_ARB_EN
//   defined   : round-robin arbitration on ties (tracks last_grant)
//   undefined : fixed priority, requester 0 wins ties
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0_valid/a/b/ready      requester 0 operand handshake
//   req1_valid/a/b/ready      requester 1 operand handshake
//   rsp_valid/p/id/ready      product response handshake
//   busy                      high while CALC or DONE
//
// WIDTH must be at least 2.
//
// state | meaning
// IDLE  | waiting for a request, arbiter drives reqN_ready
// CALC  | one shift-and-add iteration per cycle, cnt counts 0..WIDTH-1
// DONE  | product held on rsp_* until rsp_ready

module f_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module mult_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               req1_ready,
   output logic               rsp_valid,
   output logic [2*WIDTH-1:0] rsp_p,
   output logic               rsp_id,
   input  logic               rsp_ready,
   output logic               busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   // The multiplier operand lives in the low half of p; it is consumed one
   // bit per iteration as p shifts right, so no separate copy is kept.
   logic [2*WIDTH-1:0] p;
   logic [WIDTH-1:0]   a_reg;
   logic [CW-1:0]      cnt;
   logic               id;

   logic               grant0, grant1;
   logic               accept, accept_id;
   logic [WIDTH-1:0]   op_a, op_b;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     carry;
   logic [WIDTH-1:0]   sum_lo;
   logic [WIDTH:0]     sum;

   // Shared ripple adder: upper half of p plus A when the current multiplier
   // bit is set. The carry out becomes the MSB of sum.
   assign addend   = p[0] ? a_reg : '0;
   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_add
      f_adder u_fa (
         .a  (p[WIDTH+i]),
         .b  (addend[i]),
         .ci (carry[i]),
         .s  (sum_lo[i]),
         .co (carry[i+1])
      );
   end

   assign sum = {carry[WIDTH], sum_lo};

`ifdef MULT_RR_ARB_EN
   logic last_grant;

   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant;
         grant1 = !last_grant;
      end
   end
`else
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
   end
`endif

   assign op_a = accept_id ? req1_a : req0_a;
   assign op_b = accept_id ? req1_b : req0_b;

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      rsp_p      = '0;
      rsp_id     = 1'b0;
      busy       = 1'b0;
      accept     = 1'b0;
      accept_id  = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = !rst && grant0;
            req1_ready = !rst && grant1;
            accept     = req0_ready || req1_ready;
            accept_id  = req1_ready;
            if (accept) state_nxt = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == CW'(WIDTH-1)) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            rsp_p     = p;
            rsp_id    = id;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         p     <= '0;
         a_reg <= '0;
         cnt   <= '0;
         id    <= 1'b0;
`ifdef MULT_RR_ARB_EN
         last_grant <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg <= op_a;
            p     <= {{WIDTH{1'b0}}, op_b};
            cnt   <= '0;
            id    <= accept_id;
`ifdef MULT_RR_ARB_EN
            last_grant <= accept_id;
`endif
         end else if (state == CALC) begin
            p   <= {sum, p[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl (WIDTH = 4).

module tb_mult_seq_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id, rsp_ready, busy;
   logic [2*W-1:0] rsp_p;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_count = 0;
   int op_count = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_p      (rsp_p),
      .rsp_id     (rsp_id),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   always @(posedge clk) if (rsp_valid && rsp_ready) hs_count++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   // Issue one operation, check ready, latency, product, id, stall stability.
   task automatic do_op(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
      logic [2*W-1:0] exp_p;
      int lat;
      exp_p = {4'b0, a} * {4'b0, b};
      if (port == 0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end
      rsp_ready = (stall == 0);
      #1;
      check_val("req_ready", (port == 0) ? req0_ready : req1_ready, 1);
      tick();
      op_count++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(lat);
      check_val("latency", lat, W);
      check_val("rsp_p", rsp_p, exp_p);
      check_val("rsp_id", rsp_id, port);
      for (int s = 0; s < stall; s++) begin
         tick();
         check_val("stall_valid", rsp_valid, 1);
         check_val("stall_p", rsp_p, exp_p);
      end
      rsp_ready = 1'b1;
      tick();
      check_val("rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      int lat;
      logic [7:0] exp_second_p;
      logic       exp_second_id;

      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b1;
      tick();
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_rsp_p", rsp_p, 0);
      check_val("rst_rsp_id", rsp_id, 0);
      check_val("rst_req0_ready", req0_ready, 0);
      tick();
      req0_valid = 1'b0;
      rst = 1'b0;

      // First product, accepted on the first edge after reset release.
      do_op(0, 4'hF, 4'hF, 0);

      // Edge operands on requester 1.
      do_op(1, 4'h0, 4'h9, 0);
      do_op(1, 4'h7, 4'h1, 0);
      do_op(1, 4'h8, 4'h8, 1);

      // Both requesters held valid for two operations (fresh reset for RR state).
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3;
      req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h5;
      rsp_ready = 1'b1;
      #1;
      check_val("tie_req0_ready", req0_ready, 1);
      check_val("tie_req1_ready", req1_ready, 0);
      tick();
      op_count++;
      wait_rsp(lat);
      check_val("tie1_latency", lat, W);
      check_val("tie1_id", rsp_id, 0);
      check_val("tie1_p", rsp_p, 8'h06);
      tick();
      check_val("tie_idle_busy", busy, 0);
      tick();
      op_count++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(lat);
`ifdef MULT_RR_ARB_EN
      exp_second_id = 1'b1; exp_second_p = 8'h14;
`else
      exp_second_id = 1'b0; exp_second_p = 8'h06;
`endif
      check_val("tie2_latency", lat, W);
      check_val("tie2_id", rsp_id, exp_second_id);
      check_val("tie2_p", rsp_p, exp_second_p);
      tick();

      // Response stall with requester 1 waiting.
      req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h5;
      tick();
      op_count++;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h6;
      #1;
      check_val("calc_req1_ready", req1_ready, 0);
      rsp_ready = 1'b0;
      wait_rsp(lat);
      check_val("stall_latency", lat, W);
      for (int s = 0; s < 3; s++) begin
         tick();
         check_val("hold_valid", rsp_valid, 1);
         check_val("hold_p", rsp_p, 8'h0F);
         check_val("hold_req1_ready", req1_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      check_val("post_hs_busy", busy, 0);
      check_val("post_hs_req1_ready", req1_ready, 1);
      tick();
      op_count++;
      req1_valid = 1'b0;
      check_val("accept_busy", busy, 1);
      wait_rsp(lat);
      check_val("waited_latency", lat, W);
      check_val("waited_p", rsp_p, 8'h0C);
      check_val("waited_id", rsp_id, 1);
      tick();

      // Reset two edges into CALC.
      req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'hF;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      req0_valid = 1'b1;
      #1;
      check_val("midrst_busy", busy, 0);
      check_val("midrst_rsp_valid", rsp_valid, 0);
      check_val("midrst_rsp_p", rsp_p, 0);
      check_val("midrst_req0_ready", req0_ready, 0);
      req0_valid = 1'b0;
      tick();
      rst = 1'b0;
      do_op(0, 4'h5, 4'h3, 0);

      // Exhaustive sweep, alternating ports, random response stalls.
      for (int i = 0; i < 256; i++) begin
         logic [7:0] ab;
         ab = i[7:0];
         do_op(i % 2, ab[7:4], ab[3:0], $urandom_range(0, 2));
      end

      // The interrupted operation never produces a response.
      check_val("hs_count", hs_count, op_count);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
